// File: rtl/if_pc_unit.sv
// Program counter / next-PC stage: sequential, branch, JAL and JALR targets, halts on a bad target.
// pc, redirect and the status outputs update one cycle after their inputs; stall holds pc and retired.
module if_pc_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] instruction,
  input  logic [6:0]  opcode,
  input  logic [2:0]  func3,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        redirect,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [31:0] retired
);

  localparam logic [31:0] PC_LIMIT  = 32'(IMEM_WORDS * 4);
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HALT
  } state_t;

  state_t      state_q, state_nxt;
  logic [31:0] pc_q, pc_nxt;
  logic [31:0] retired_q, retired_nxt;
  logic [31:0] fault_pc_q, fault_pc_nxt;
  logic        redirect_q, redirect_nxt;
  logic        halted_q, halted_nxt;
  logic        fault_q, fault_nxt;

  logic [31:0] imm_i, imm_b, imm_j;
  logic [31:0] seq_pc;
  logic [31:0] next_pc;
  logic        taken;
  logic        branch_cond;
  logic        bad_target;
  logic        unused_opcode_bits;

  // The opcode field arrives already decoded on its own port.
  assign unused_opcode_bits = ^instruction[6:0];

  assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};
  assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                  instruction[20], instruction[30:21], 1'b0};

  assign seq_pc = pc_q + 32'd4;

  always_comb begin
    branch_cond = 1'b0;
    case (func3)
      3'b000:  branch_cond = (rs1_data == rs2_data);
      3'b001:  branch_cond = (rs1_data != rs2_data);
      3'b100:  branch_cond = ($signed(rs1_data) <  $signed(rs2_data));
      3'b101:  branch_cond = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  branch_cond = (rs1_data <  rs2_data);
      3'b111:  branch_cond = (rs1_data >= rs2_data);
      default: branch_cond = 1'b0;
    endcase
  end

  always_comb begin
    next_pc = seq_pc;
    taken   = 1'b0;
    case (opcode)
      OP_BRANCH: begin
        if (branch_cond) begin
          next_pc = pc_q + imm_b;
          taken   = 1'b1;
        end
      end
      OP_JAL: begin
        next_pc = pc_q + imm_j;
        taken   = 1'b1;
      end
      OP_JALR: begin
        next_pc = (rs1_data + imm_i) & ~32'h1;
        taken   = 1'b1;
      end
      default: begin
        next_pc = seq_pc;
        taken   = 1'b0;
      end
    endcase
  end

  // Sequential fall-through off the end of memory is caught by the range check too.
  assign bad_target = (next_pc[1:0] != 2'b00) || (next_pc >= PC_LIMIT);

  always_comb begin
    state_nxt    = state_q;
    pc_nxt       = pc_q;
    retired_nxt  = retired_q;
    fault_pc_nxt = fault_pc_q;
    redirect_nxt = 1'b0;
    halted_nxt   = halted_q;
    fault_nxt    = fault_q;
    case (state_q)
      ST_BOOT: begin
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!stall) begin
          if (bad_target) begin
            state_nxt    = ST_HALT;
            halted_nxt   = 1'b1;
            fault_nxt    = 1'b1;
            fault_pc_nxt = pc_q;
          end else begin
            pc_nxt       = next_pc;
            retired_nxt  = retired_q + 32'd1;
            redirect_nxt = taken;
          end
        end
      end
      ST_HALT: begin
        halted_nxt = 1'b1;
      end
      default: begin
        state_nxt = ST_HALT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      retired_q  <= 32'd0;
      fault_pc_q <= 32'd0;
      redirect_q <= 1'b0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      pc_q       <= pc_nxt;
      retired_q  <= retired_nxt;
      fault_pc_q <= fault_pc_nxt;
      redirect_q <= redirect_nxt;
      halted_q   <= halted_nxt;
      fault_q    <= fault_nxt;
    end
  end

  assign pc       = pc_q;
  assign pc_plus4 = seq_pc;
  assign redirect = redirect_q;
  assign halted   = halted_q;
  assign fault    = fault_q;
  assign fault_pc = fault_pc_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_if_pc_unit.sv
// Table-driven bench for if_pc_unit: each row is one clock of stimulus plus the expected post-edge state.
module tb_if_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [31:0] instruction;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [31:0] rs1_data, rs2_data;
  logic [31:0] pc, pc_plus4, fault_pc, retired;
  logic        redirect, halted, fault;

  localparam logic [31:0] NOP = 32'h0000_0013;

  if_pc_unit #(.RESET_PC(32'h0), .IMEM_WORDS(64)) dut (
    .clk(clk), .rst(rst), .stall(stall), .instruction(instruction),
    .opcode(opcode), .func3(func3), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .pc(pc), .pc_plus4(pc_plus4), .redirect(redirect), .halted(halted),
    .fault(fault), .fault_pc(fault_pc), .retired(retired)
  );

  always #5 clk = ~clk;

  assign opcode = instruction[6:0];
  assign func3  = instruction[14:12];

  typedef struct {
    int          ph;
    logic        stall;
    logic [31:0] inst, rs1, rs2;
    logic [31:0] pc, ret, fpc;
    logic        red, hlt, flt;
  } vec_t;

  vec_t        tab[$];
  vec_t        sb[$];
  vec_t        zero_v;
  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] cur_pc;

  function automatic logic [31:0] enc_j(input logic [31:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [2:0] f3);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  task automatic add(input int ph, input logic st, input logic [31:0] inst,
                     input logic [31:0] r1, input logic [31:0] r2,
                     input logic [31:0] epc, input logic ered, input logic [31:0] eret,
                     input logic ehlt, input logic eflt, input logic [31:0] efpc);
    vec_t v;
    v.ph = ph; v.stall = st; v.inst = inst; v.rs1 = r1; v.rs2 = r2;
    v.pc = epc; v.red = ered; v.ret = eret; v.hlt = ehlt; v.flt = eflt; v.fpc = efpc;
    tab.push_back(v);
  endtask

  task automatic check_out(input string name, input vec_t e);
    n_vec++;
    if (pc !== e.pc || redirect !== e.red || halted !== e.hlt || fault !== e.flt ||
        fault_pc !== e.fpc || retired !== e.ret) begin
      n_bad++;
      $display("FAIL %s: got pc=%h red=%b hlt=%b flt=%b fpc=%h ret=%0d, want pc=%h red=%b hlt=%b flt=%b fpc=%h ret=%0d",
               name, pc, redirect, halted, fault, fault_pc, retired,
               e.pc, e.red, e.hlt, e.flt, e.fpc, e.ret);
    end
  endtask

  task automatic run_phase(input int ph);
    vec_t e;
    for (int k = 0; k < tab.size(); k++) begin
      if (tab[k].ph == ph) begin
        @(negedge clk);
        stall       = tab[k].stall;
        instruction = tab[k].inst;
        rs1_data    = tab[k].rs1;
        rs2_data    = tab[k].rs2;
        #1;
        n_vec++;
        if (pc_plus4 !== cur_pc + 32'd4) begin
          n_bad++;
          $display("FAIL pc_plus4 row %0d: got %h, want %h", k, pc_plus4, cur_pc + 32'd4);
        end
        sb.push_back(tab[k]);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_out($sformatf("row%0d", k), e);
        cur_pc = e.pc;
      end
    end
  endtask

  initial begin
    zero_v = '{ph: 0, stall: 1'b0, inst: 32'h0, rs1: 32'h0, rs2: 32'h0,
               pc: 32'h0, ret: 32'h0, fpc: 32'h0, red: 1'b0, hlt: 1'b0, flt: 1'b0};

    // Phase 0: boot, sequential flow, stalls, every branch flavour, JAL, JALR, misaligned JALR halt.
    add(0, 0, NOP,                 0, 0,           32'h00, 0, 0,  0, 0, 0);
    add(0, 0, NOP,                 0, 0,           32'h04, 0, 1,  0, 0, 0);
    add(0, 0, NOP,                 0, 0,           32'h08, 0, 2,  0, 0, 0);
    add(0, 0, NOP,                 0, 0,           32'h0C, 0, 3,  0, 0, 0);
    add(0, 0, enc_j(32'h10),       0, 0,           32'h1C, 1, 4,  0, 0, 0);
    add(0, 1, 32'h00F71E63,        1, 2,           32'h1C, 0, 4,  0, 0, 0);
    add(0, 1, 32'h00008067,        32'h82, 0,      32'h1C, 0, 4,  0, 0, 0);
    add(0, 1, NOP,                 0, 0,           32'h1C, 0, 4,  0, 0, 0);
    add(0, 0, 32'h00F71E63,        1, 2,           32'h38, 1, 5,  0, 0, 0);
    add(0, 0, NOP,                 0, 0,           32'h3C, 0, 6,  0, 0, 0);
    add(0, 0, enc_j(-32'sd32),     0, 0,           32'h1C, 1, 7,  0, 0, 0);
    add(0, 0, 32'h00F71E63,        2, 2,           32'h20, 0, 8,  0, 0, 0);
    add(0, 0, enc_b(8, 3'b100),    32'hFFFF_FFFF, 1, 32'h28, 1, 9,  0, 0, 0);
    add(0, 0, enc_b(8, 3'b110),    32'hFFFF_FFFF, 1, 32'h2C, 0, 10, 0, 0, 0);
    add(0, 0, enc_b(16, 3'b111),   32'hFFFF_FFFF, 1, 32'h3C, 1, 11, 0, 0, 0);
    add(0, 0, enc_b(8, 3'b101),    32'hFFFF_FFFF, 1, 32'h40, 0, 12, 0, 0, 0);
    add(0, 0, enc_b(8, 3'b010),    3, 3,           32'h44, 0, 13, 0, 0, 0);
    add(0, 0, enc_b(32'h38, 3'b000), 5, 5,         32'h7C, 1, 14, 0, 0, 0);
    add(0, 0, 32'hF85FF0EF,        0, 0,           32'h00, 1, 15, 0, 0, 0);
    add(0, 0, 32'h00008067,        32'h81, 0,      32'h80, 1, 16, 0, 0, 0);
    add(0, 0, 32'h00008067,        32'h82, 0,      32'h80, 0, 16, 1, 1, 32'h80);
    add(0, 0, NOP,                 0, 0,           32'h80, 0, 16, 1, 1, 32'h80);
    add(0, 1, NOP,                 0, 0,           32'h80, 0, 16, 1, 1, 32'h80);

    // Phase 1: after async reset, boot again, jump near the top and fall off the end of memory.
    add(1, 0, NOP,                 0, 0,           32'h00, 0, 0,  0, 0, 0);
    add(1, 0, NOP,                 0, 0,           32'h04, 0, 1,  0, 0, 0);
    add(1, 0, enc_j(32'hF4),       0, 0,           32'hF8, 1, 2,  0, 0, 0);
    add(1, 0, NOP,                 0, 0,           32'hFC, 0, 3,  0, 0, 0);
    add(1, 0, NOP,                 0, 0,           32'hFC, 0, 3,  1, 1, 32'hFC);
    add(1, 0, NOP,                 0, 0,           32'hFC, 0, 3,  1, 1, 32'hFC);

    rst = 1'b0; stall = 1'b0; instruction = NOP; rs1_data = 0; rs2_data = 0;
    #12;
    check_out("reset", zero_v);
    @(posedge clk);
    #1 rst = 1'b1;
    cur_pc = 32'h0;
    run_phase(0);

    // Reset dropped mid-cycle while halted must clear everything before the next edge.
    @(negedge clk);
    #1 rst = 1'b0;
    #1 check_out("async_rst", zero_v);
    @(posedge clk);
    #1 check_out("rst_held", zero_v);
    rst = 1'b1;
    cur_pc = 32'h0;
    run_phase(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
